// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter: grants one requester at a time (alternating on ties) and holds its request on the memory bus until completion.
// Build option `MEM_ARB_TIMEOUT_EN aborts a bus request after TIMEOUT_CYCLES cycles without mem_ready.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;  // 0 = fetch, 1 = data
  logic   gnt;         // port owning the current transaction
  logic   grant_sel;
  logic   done;
  logic   tmo;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo = (state == REQ) && !mem_ready && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Held at zero outside REQ so every REQ entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != REQ) begin
      tmo_cnt <= '0;
    end else if (!mem_ready) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign done = (state == REQ) && (mem_ready || tmo);

  always_comb begin
    grant_sel = 1'b0;
    if (i_valid && d_valid) begin
      grant_sel = ~last_grant;
    end else if (d_valid) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid || d_valid) state_nxt = REQ;
      REQ:     if (done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      i_ready    <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
      if (state == IDLE && (i_valid || d_valid)) begin
        gnt       <= grant_sel;
        mem_valid <= 1'b1;
        mem_instr <= ~grant_sel;
        mem_addr  <= grant_sel ? d_addr : i_addr;
        mem_wdata <= grant_sel ? d_wdata : 32'h0;
        mem_wstrb <= grant_sel ? d_wstrb : 4'h0;
      end
      if (done) begin
        mem_valid  <= 1'b0;
        last_grant <= gnt;
        if (gnt) begin
          d_ready <= 1'b1;
          d_rdata <= tmo ? 32'h0 : mem_rdata;
          d_err   <= tmo;
        end else begin
          i_ready <= 1'b1;
          i_rdata <= tmo ? 32'h0 : mem_rdata;
          i_err   <= tmo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected bus/response entries; responder and monitor pop and compare.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid, i_ready, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_ready, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct packed {logic instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} bus_t;
  typedef struct packed {logic [15:0] wait_c; logic [31:0] data;} mem_t;
  typedef struct packed {logic port; logic [31:0] rdata; logic err;} rsp_t;

  bus_t bus_q[$];
  mem_t mem_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_ready"}, 32'(i_ready), 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_i_err"}, 32'(i_err), 0);
    chk({tag, "_d_ready"}, 32'(d_ready), 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_d_err"}, 32'(d_err), 0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 0);
    chk({tag, "_mem_instr"}, 32'(mem_instr), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 0);
  endtask

  task automatic fetch(input logic [31:0] a, output int lat);
    i_valid = 1'b1;
    i_addr  = a;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!i_ready && lat < 200);
    if (!i_ready) chk("fetch_wait_expired", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic data(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, output int lat);
    d_valid = 1'b1;
    d_addr  = a;
    d_wdata = wd;
    d_wstrb = ws;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d_ready && lat < 200);
    if (!d_ready) chk("data_wait_expired", 0, 1);
    d_valid = 1'b0;
  endtask

  // Memory model: checks the latched bus request, then answers after wait_c extra cycles.
  initial begin : responder
    bus_t b;
    mem_t m;
    int   n;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_valid) begin
        if (bus_q.size() == 0 || mem_q.size() == 0) begin
          chk("bus_unexpected", 1, 0);
          m = '{wait_c: 16'hFFFF, data: 32'h0};
        end else begin
          b = bus_q.pop_front();
          m = mem_q.pop_front();
          chk("bus_instr", 32'(mem_instr), 32'(b.instr));
          chk("bus_addr", mem_addr, b.addr);
          chk("bus_wdata", mem_wdata, b.wdata);
          chk("bus_wstrb", 32'(mem_wstrb), 32'(b.wstrb));
        end
        n = 0;
        while (rst_n && mem_valid && n < 2000) begin
          if (n == int'(m.wait_c)) begin
            mem_ready = 1'b1;
            mem_rdata = m.data;
          end
          @(negedge clk);
          mem_ready = 1'b0;
          mem_rdata = 32'h5A5A5A5A;
          n++;
        end
        req_cycles = n;
      end
    end
  end

  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (i_ready || d_ready)) begin
        if (i_ready && d_ready) chk("ready_both", 1, 0);
        if (rsp_q.size() == 0) begin
          chk("ready_unexpected", 32'({i_ready, d_ready}), 0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_port", 32'(d_ready), 32'(r.port));
          chk("rsp_rdata", d_ready ? d_rdata : i_rdata, r.rdata);
          chk("rsp_err", 32'(d_ready ? d_err : i_err), 32'(r.err));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, two wait cycles; data-port payload must not leak onto the bus.
    d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF;
    bus_q.push_back('{1'b1, 32'h00000100, 32'h0, 4'h0});
    mem_q.push_back('{16'd2, 32'h00000013});
    rsp_q.push_back('{1'b0, 32'h00000013, 1'b0});
    fetch(32'h00000100, lat);
    chk("fetch_latency", lat, 4);
    @(negedge clk);
    chk("fetch_req_cycles", req_cycles, 3);
    chk("hold_i_rdata", i_rdata, 32'h00000013);
    chk("hold_mem_addr", mem_addr, 32'h00000100);
    chk("idle_mem_valid", 32'(mem_valid), 0);

    // Zero-wait byte store.
    bus_q.push_back('{1'b0, 32'h00000203, 32'hAB000000, 4'b1000});
    mem_q.push_back('{16'd0, 32'hDEADBEEF});
    rsp_q.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    data(32'h00000203, 32'hAB000000, 4'b1000, lat);
    chk("store_latency", lat, 2);
    @(negedge clk);

    // Both ports continuously valid from reset: strict I,D,I,D,I,D.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_q.push_back('{1'b1, 32'h00001000, 32'h0, 4'h0});         mem_q.push_back('{16'd0, 32'hA0000000});
    bus_q.push_back('{1'b0, 32'h00002000, 32'h0, 4'h0});         mem_q.push_back('{16'd1, 32'hA1000001});
    bus_q.push_back('{1'b1, 32'h00001004, 32'h0, 4'h0});         mem_q.push_back('{16'd0, 32'hA2000002});
    bus_q.push_back('{1'b0, 32'h00002004, 32'h0, 4'h0});         mem_q.push_back('{16'd2, 32'hA3000003});
    bus_q.push_back('{1'b1, 32'h00001008, 32'h0, 4'h0});         mem_q.push_back('{16'd0, 32'hA4000004});
    bus_q.push_back('{1'b0, 32'h00002008, 32'h11223344, 4'hF});  mem_q.push_back('{16'd0, 32'hA5000005});
    rsp_q.push_back('{1'b0, 32'hA0000000, 1'b0});
    rsp_q.push_back('{1'b1, 32'hA1000001, 1'b0});
    rsp_q.push_back('{1'b0, 32'hA2000002, 1'b0});
    rsp_q.push_back('{1'b1, 32'hA3000003, 1'b0});
    rsp_q.push_back('{1'b0, 32'hA4000004, 1'b0});
    rsp_q.push_back('{1'b1, 32'hA5000005, 1'b0});
    fork
      begin : fetch_side
        int l;
        fetch(32'h00001000, l);
        fetch(32'h00001004, l);
        fetch(32'h00001008, l);
      end
      begin : data_side
        int l;
        data(32'h00002000, 32'h0, 4'h0, l);
        data(32'h00002004, 32'h0, 4'h0, l);
        data(32'h00002008, 32'h11223344, 4'hF, l);
      end
    join
    @(negedge clk);
    chk("alt_rsp_drained", rsp_q.size(), 0);

    // Reset in the middle of a stalled data request; request stays pending and is retried.
    d_valid = 1'b1; d_addr = 32'h00000400; d_wdata = 32'h0; d_wstrb = 4'h0;
    bus_q.push_back('{1'b0, 32'h00000400, 32'h0, 4'h0});
    mem_q.push_back('{16'hFFFF, 32'h0});
    lat = 0;
    while (!mem_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_mem_valid_seen", 32'(mem_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreq_reset");
    @(negedge clk);
    bus_q.push_back('{1'b0, 32'h00000400, 32'h0, 4'h0});
    mem_q.push_back('{16'd1, 32'h00000044});
    rsp_q.push_back('{1'b1, 32'h00000044, 1'b0});
    rst_n = 1'b1;
    data(32'h00000400, 32'h0, 4'h0, lat);
    chk("retry_latency", lat, 3);
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after four REQ cycles.
    bus_q.push_back('{1'b0, 32'h00000300, 32'h0, 4'h0});
    mem_q.push_back('{16'hFFFF, 32'h0});
    rsp_q.push_back('{1'b1, 32'h0, 1'b1});
    data(32'h00000300, 32'h0, 4'h0, lat);
    @(negedge clk);
    chk("timeout_req_cycles", req_cycles, 4);

    // mem_ready in the fourth REQ cycle beats the timeout.
    bus_q.push_back('{1'b0, 32'h00000304, 32'h0, 4'h0});
    mem_q.push_back('{16'd3, 32'hCAFEF00D});
    rsp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0});
    data(32'h00000304, 32'h0, 4'h0, lat);
    @(negedge clk);
    chk("late_ready_req_cycles", req_cycles, 4);
`endif

    repeat (3) @(negedge clk);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
